// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl_pkg
// Purpose  : Shared definitions for the bit-serial adder controller:
//            FSM state encodings and default size constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Default operand width and matching bit-counter width (2**CNT_W > WIDTH).
   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 4;

endpackage : serial_adder_ctrl_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : fa_cell
// Purpose  : Combinational 1-bit full adder; the single shared datapath cell
//            of the bit-serial adder.
// Ports    : a, b, cin - addend bits and carry-in
//            s, cout   - sum bit and carry-out
// Revision : 1.0 - initial release
// ============================================================================
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial adder controller. Computes a WIDTH-bit sum over WIDTH
//            clock cycles with one shared 1-bit full-adder cell, LSB first,
//            and hands the result to the host with a start/done handshake.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            start           - request a new operation (sampled in IDLE only)
//            a, b, cin       - operands and carry-in, captured on start
//            sub             - subtract select (only with SERIAL_ADDER_SUB_EN)
//            busy            - computation in progress
//            done            - one-cycle pulse, sum/cout valid
//            sum, cout       - result, held until the next accepted start
// Config   : define SERIAL_ADDER_SUB_EN to add the sub port (a - b mode,
//            cout = 1 means no borrow).
// Params   : WIDTH >= 2; CNT_W with 2**CNT_W > WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
   ,
   input  logic             sub
`endif
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic             w_busy;
   logic             w_done;

   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_run;
   logic             w_last;
   logic             w_fa_b;
   logic             w_fa_s;
   logic             w_fa_co;
   logic             w_init_carry;

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_busy = 1'b1;
            if (r_cnt == C_LAST) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_run    = (r_state == ST_RUN);
   assign w_last   = w_run && (r_cnt == C_LAST);

   // ------------------------------------------------------------------------
   // Operand conditioning: subtraction is a + ~b + 1, so invert the B bit
   // into the cell and force the initial carry high.
   // ------------------------------------------------------------------------
`ifdef SERIAL_ADDER_SUB_EN
   logic r_sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sub <= 1'b0;
      end else if (w_accept) begin
         r_sub <= sub;
      end
   end

   assign w_fa_b       = r_sb[0] ^ r_sub;
   assign w_init_carry = sub | cin;
`else
   assign w_fa_b       = r_sb[0];
   assign w_init_carry = cin;
`endif

   fa_cell u_fa_cell (
      .a    (r_sa[0]),
      .b    (w_fa_b),
      .cin  (r_carry),
      .s    (w_fa_s),
      .cout (w_fa_co)
   );

   // ------------------------------------------------------------------------
   // Datapath: operand/result shift registers, carry feedback, bit counter.
   // The visible result register is loaded only on the last RUN edge so the
   // host never sees partial sums.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_sa    <= a;
         r_sb    <= b;
         r_res   <= '0;
         r_carry <= w_init_carry;
         r_cnt   <= '0;
      end else if (w_run) begin
         r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
         r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
         r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
         r_carry <= w_fa_co;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            r_sum  <= {w_fa_s, r_res[WIDTH-1:1]};
            r_cout <= w_fa_co;
         end
      end
   end

   assign busy = w_busy;
   assign done = w_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule : serial_adder_ctrl
`default_nettype wire
